// File: rtl/ctrl_pkg.sv
// Shared decode constants, condition codes, sequencer states and the
// strobe bundle for the single-cycle RISC control unit.
package ctrl_pkg;

    localparam logic [4:0] OP_ALU   = 5'b00000;
    localparam logic [4:0] OP_LHI   = 5'b00001;
    localparam logic [4:0] OP_LLI   = 5'b00010;
    localparam logic [4:0] OP_LDR   = 5'b00011;
    localparam logic [4:0] OP_STR   = 5'b00101;
    localparam logic [4:0] OP_ADDI  = 5'b00111;
    localparam logic [4:0] OP_SUBI  = 5'b01000;
    localparam logic [4:0] OP_JMP   = 5'b10000;
    localparam logic [4:0] OP_JAL1  = 5'b10001;
    localparam logic [4:0] OP_JAL2  = 5'b10010;
    localparam logic [4:0] OP_JR    = 5'b10011;
    localparam logic [4:0] OP_BCC_0 = 5'b11000;
    localparam logic [4:0] OP_BCC_1 = 5'b11001;
    localparam logic [4:0] OP_SYS   = 5'b11100;

    localparam logic [1:0] FUNCT_ADD = 2'b00;
    localparam logic [1:0] FUNCT_ADC = 2'b01;
    localparam logic [1:0] FUNCT_SUB = 2'b10;
    localparam logic [1:0] FUNCT_SBB = 2'b11;

    localparam logic [1:0] SYS_OUTR = 2'b00;
    localparam logic [1:0] SYS_HLT  = 2'b01;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic data_write_en;
        logic flag_label_pc;
        logic flag_rm_pc;
        logic flag_rd_pc;
        logic branch;
        logic adc;
        logic sub;
        logic sbb;
        logic jmp;
        logic src_alu_b;
        logic src_read_b;
        logic flag_mem_rf;
        logic flag_alu_rf;
        logic flag_rm_rf;
        logic flag_pc_rf;
        logic lhi;
        logic lli;
        logic rf_write_en;
        logic flag_outr;
    } strobes_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition-code evaluator for conditional branches.
module branch_cond_eval
    import ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       c,
    input  logic       v,
    input  logic       z,
    input  logic       n,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (cond)
            COND_EQ: take = z;
            COND_NE: take = !z;
            COND_CS: take = c;
            COND_CC: take = !c;
            COND_MI: take = n;
            COND_PL: take = !n;
            COND_VS: take = v;
            COND_VC: take = !v;
            COND_HI: take = c && !z;
            COND_LS: take = !c || z;
            COND_GE: take = (n == v);
            COND_LT: take = (n != v);
            COND_GT: take = !z && (n == v);
            COND_LE: take = z || (n != v);
            COND_AL: take = 1'b1;
            COND_NV: take = 1'b0;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Instruction decoder and LOAD/CLEAR/RUN/HALT sequencer driving the datapath.
// state | meaning
// LOAD  | external memory load, PC frozen, strobes idle
// CLEAR | one-cycle datapath clear; flags, count and illegal reset on entry
// RUN   | strobes decoded combinationally from instr
// HALT  | PC frozen after HLT, waits for start or load_req
module control_unit
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        load_req,
    input  logic [15:0] instr,
    input  logic        Pre_C,
    input  logic        Pre_V,
    input  logic        Pre_Z,
    input  logic        Pre_N,
    output logic        dp_clr,
    output logic        test_normal,
    output logic        flag_HLT,
    output logic        data_write_en,
    output logic        flag_label_PC,
    output logic        flag_Rm_PC,
    output logic        flag_Rd_PC,
    output logic        BRANCH,
    output logic        ADC,
    output logic        SUB,
    output logic        SBB,
    output logic        JMP,
    output logic        Src_ALU_B,
    output logic        Src_Read_B,
    output logic        flag_mem_RF,
    output logic        flag_ALU_RF,
    output logic        flag_Rm_RF,
    output logic        flag_PC_RF,
    output logic        LHI,
    output logic        LLI,
    output logic        RF_write_en,
    output logic        flag_OutR,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instr_count
);

    state_t     state;
    state_t     next_state;
    logic [3:0] cc_flags;
    logic [4:0] opcode;
    logic [1:0] funct;
    logic       take;
    logic       run;
    strobes_t   dec;
    strobes_t   str;
    logic       dec_illegal;
    logic       dec_hlt;
    logic       dec_flags_we;
    logic       unused_instr_bits;

    assign opcode            = instr[15:11];
    assign funct             = instr[1:0];
    assign run               = (state == ST_RUN);
    assign unused_instr_bits = ^instr[7:2];

    // cc_flags is {C,V,Z,N}
    branch_cond_eval u_branch_cond_eval (
        .cond (instr[11:8]),
        .c    (cc_flags[3]),
        .v    (cc_flags[2]),
        .z    (cc_flags[1]),
        .n    (cc_flags[0]),
        .take (take)
    );

    always_comb begin
        dec          = '0;
        dec_illegal  = 1'b0;
        dec_hlt      = 1'b0;
        dec_flags_we = 1'b0;
        case (opcode)
            OP_ALU: begin
                dec.flag_alu_rf = 1'b1;
                dec.rf_write_en = 1'b1;
                dec_flags_we    = 1'b1;
                case (funct)
                    FUNCT_ADC: dec.adc = 1'b1;
                    FUNCT_SUB: dec.sub = 1'b1;
                    FUNCT_SBB: dec.sbb = 1'b1;
                    default:   dec.adc = 1'b0;
                endcase
            end
            OP_LHI: begin
                dec.lhi         = 1'b1;
                dec.src_read_b  = 1'b1;
                dec.rf_write_en = 1'b1;
            end
            OP_LLI: begin
                dec.lli         = 1'b1;
                dec.rf_write_en = 1'b1;
            end
            OP_LDR: begin
                dec.src_alu_b   = 1'b1;
                dec.flag_mem_rf = 1'b1;
                dec.rf_write_en = 1'b1;
            end
            OP_STR: begin
                dec.src_alu_b     = 1'b1;
                dec.src_read_b    = 1'b1;
                dec.data_write_en = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
                dec.src_alu_b   = 1'b1;
                dec.flag_alu_rf = 1'b1;
                dec.rf_write_en = 1'b1;
                dec.sub         = (opcode == OP_SUBI);
                dec_flags_we    = 1'b1;
            end
            OP_BCC_0, OP_BCC_1: dec.branch = take;
            OP_JMP: begin
                dec.flag_label_pc = 1'b1;
                dec.jmp           = 1'b1;
            end
            OP_JAL1: begin
                dec.branch      = 1'b1;
                dec.flag_pc_rf  = 1'b1;
                dec.rf_write_en = 1'b1;
            end
            OP_JAL2: begin
                dec.flag_rm_pc  = 1'b1;
                dec.jmp         = 1'b1;
                dec.flag_pc_rf  = 1'b1;
                dec.rf_write_en = 1'b1;
            end
            OP_JR: begin
                dec.flag_rd_pc = 1'b1;
                dec.jmp        = 1'b1;
                dec.src_read_b = 1'b1;
            end
            OP_SYS: begin
                case (funct)
                    SYS_OUTR: dec.flag_outr = 1'b1;
                    SYS_HLT:  dec_hlt       = 1'b1;
                    default:  dec_illegal   = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign str = run ? dec : '0;

    assign data_write_en = str.data_write_en;
    assign flag_label_PC = str.flag_label_pc;
    assign flag_Rm_PC    = str.flag_rm_pc;
    assign flag_Rd_PC    = str.flag_rd_pc;
    assign BRANCH        = str.branch;
    assign ADC           = str.adc;
    assign SUB           = str.sub;
    assign SBB           = str.sbb;
    assign JMP           = str.jmp;
    assign Src_ALU_B     = str.src_alu_b;
    assign Src_Read_B    = str.src_read_b;
    assign flag_mem_RF   = str.flag_mem_rf;
    assign flag_ALU_RF   = str.flag_alu_rf;
    assign flag_Rm_RF    = str.flag_rm_rf;
    assign flag_PC_RF    = str.flag_pc_rf;
    assign LHI           = str.lhi;
    assign LLI           = str.lli;
    assign RF_write_en   = str.rf_write_en;
    assign flag_OutR     = str.flag_outr;

    // HLT must freeze the PC in the very cycle it is decoded.
    assign flag_HLT = run && !dec_hlt;

    always_comb begin
        next_state = state;
        if (load_req) begin
            next_state = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD:  if (start) next_state = ST_CLEAR;
                ST_CLEAR: next_state = ST_RUN;
                ST_RUN:   if (dec_hlt) next_state = ST_HALT;
                ST_HALT:  if (start) next_state = ST_CLEAR;
                default:  next_state = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= ST_LOAD;
            test_normal <= 1'b1;
            dp_clr      <= 1'b0;
            halted      <= 1'b0;
            cc_flags    <= 4'b0000;
            instr_count <= 16'h0000;
            illegal     <= 1'b0;
        end else begin
            state       <= next_state;
            test_normal <= (next_state == ST_LOAD);
            dp_clr      <= (next_state == ST_CLEAR);
            halted      <= (next_state == ST_HALT);
            if (next_state == ST_CLEAR) begin
                cc_flags    <= 4'b0000;
                instr_count <= 16'h0000;
                illegal     <= 1'b0;
            end else if (run) begin
                if (dec_flags_we)
                    cc_flags <= {Pre_C, Pre_V, Pre_Z, Pre_N};
                if (instr_count != 16'hFFFF)
                    instr_count <= instr_count + 16'h0001;
                if (dec_illegal)
                    illegal <= 1'b1;
            end
        end
    end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction decoder and run-mode sequencer for the single-cycle RISC. It sits directly upstream of `Datapath_Module`. It consumes `mem_instr_out` and the `Pre_C/V/Z/N` flags, and drives every datapath control strobe. It also drives the test/normal, clear and halt controls. It owns the latched condition-code register, a load/clear/run/halt FSM, a retired-instruction counter and a sticky illegal-opcode flag.

## Interface
- No parameters. Widths are fixed at 16-bit instructions and a 16-bit counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `start` in 1: leave LOAD or HALT and begin execution.
- `load_req` in 1: return to LOAD from any state. Has priority over `start`.
- `instr` in 16: wired from datapath `mem_instr_out`.
- `Pre_C`, `Pre_V`, `Pre_Z`, `Pre_N` in 1 each: ALU flags of the current instruction.
- `dp_clr` out 1: datapath clear pulse.
- `test_normal` out 1: 1 = external memory-load mode.
- `flag_HLT` out 1: 0 freezes the PC.
- Datapath strobes, out 1 each: `data_write_en`, `flag_label_PC`, `flag_Rm_PC`, `flag_Rd_PC`, `BRANCH`, `ADC`, `SUB`, `SBB`, `JMP`, `Src_ALU_B`, `Src_Read_B`, `flag_mem_RF`, `flag_ALU_RF`, `flag_Rm_RF`, `flag_PC_RF`, `LHI`, `LLI`, `RF_write_en`, `flag_OutR`.
- `halted` out 1: state is HALT.
- `illegal` out 1: sticky; an undefined opcode has executed.
- `instr_count` out 16: retired instructions, saturating.

## Operation
- FSM states: LOAD, CLEAR, RUN, HALT. Reset enters LOAD.
- LOAD: `test_normal=1`, `flag_HLT=0`, all strobes 0.
  - `start` → CLEAR.
- CLEAR: lasts exactly one cycle. `dp_clr=1`, `test_normal=0`, `flag_HLT=0`, strobes 0. Clears the flag register, `instr_count` and `illegal`. Always → RUN.
- RUN: `test_normal=0`, `flag_HLT=1` except on HLT. Strobes are decoded combinationally from `instr`.
- HALT: `flag_HLT=0`, strobes 0.
  - `start` → CLEAR (restart from PC 0).
- `load_req` in any non-reset state → LOAD.
- Decode by `instr[15:11]`. Every strobe not listed is 0.
  - 00000 ALU-reg. `funct=instr[1:0]`: 00 ADD, 01 ADC (`ADC`), 10 SUB (`SUB`), 11 SBB (`SBB`). All variants drive `flag_ALU_RF`, `RF_write_en`.
  - 00001 LHI: `LHI`, `Src_Read_B`, `RF_write_en`.
  - 00010 LLI: `LLI`, `RF_write_en`.
  - 00011 LDR: `Src_ALU_B`, `flag_mem_RF`, `RF_write_en`.
  - 00101 STR: `Src_ALU_B`, `Src_Read_B`, `data_write_en`.
  - 00111 ADDI: `Src_ALU_B`, `flag_ALU_RF`, `RF_write_en`.
  - 01000 SUBI: as ADDI, plus `SUB`.
  - 1100x Bcc (`instr[15:12]=1100`): `BRANCH` = cond(`instr[11:8]`) evaluated against the latched flags.
  - 10000 JMP: `flag_label_PC`, `JMP`.
  - 10001 JAL1: `BRANCH`, `flag_PC_RF`, `RF_write_en`.
  - 10010 JAL2: `flag_Rm_PC`, `JMP`, `flag_PC_RF`, `RF_write_en`.
  - 10011 JR: `flag_Rd_PC`, `JMP`, `Src_Read_B`.
  - 11100 with `funct` 00: OutR, drives `flag_OutR`.
  - 11100 with `funct` 01: HLT, drives `flag_HLT=0`.
  - Anything else: NOP (all strobes 0) and sets `illegal`.
- Condition codes:
  - 0 EQ (Z), 1 NE (!Z), 2 CS (C), 3 CC (!C).
  - 4 MI (N), 5 PL (!N), 6 VS (V), 7 VC (!V).
  - 8 HI (C&!Z), 9 LS (!C|Z), A GE (N==V), B LT (N!=V).
  - C GT (!Z&N==V), D LE (Z|N!=V), E AL (always), F NV (never).
- Flag register {C,V,Z,N} loads `Pre_*` at the edge ending a RUN cycle of ALU-reg, ADDI or SUBI. It holds otherwise.

## Timing
- Decode is combinational, with zero-cycle latency from `instr` to the strobes. This is a single-cycle machine.
- A Bcc sees flags written by the previous ALU instruction, never by itself.
- HLT: `flag_HLT=0` in the same cycle; `halted=1` from the next edge.
- `instr_count` increments at each RUN-cycle edge, including HLT. It saturates at 0xFFFF.
- Reset values:
  - State LOAD, so `test_normal=1`.
  - `dp_clr=0`, `flag_HLT=0`, all strobes 0.
  - Flags 0000, `instr_count=0`, `illegal=0`, `halted=0`.
- `load_req` and `start` asserted together: `load_req` wins.
- `clr` mid-RUN: next cycle is LOAD with all reset values.

## Structure
- `ctrl_pkg` holds:
  - opcode localparams
  - ALU `funct` codes
  - the 4-bit condition-code constants
  - the FSM state enum
- One natural sub-module: `branch_cond_eval`. It is combinational and maps (cond[3:0], C, V, Z, N) → take.

## Test plan
- Reset, then `start`: LOAD → CLEAR (`dp_clr=1` for exactly 1 cycle) → RUN, with `test_normal` 1 → 0.
- RUN with `instr=16'b00000_011_001_010_10`: `SUB=1`, `flag_ALU_RF=1`, `RF_write_en=1`, all other strobes 0.
- SUBI with `Pre_Z=1`, then `instr=16'hC000` (BEQ): `BRANCH=1`. Repeat with `Pre_Z=0`: `BRANCH=0`. `16'hCE07` always gives `BRANCH=1`; `16'hCF07` always gives 0.
- `instr=16'b11100_000_000_000_01`: `flag_HLT=0` in the same cycle; `halted=1` next cycle. Then `start`: one `dp_clr` pulse and `instr_count` back to 0.
- `instr=16'hF800` in RUN: all strobes 0 and `illegal=1`, which stays set until CLEAR.
- Preload `instr_count` to 0xFFFE, then run 3 cycles: the count reads 0xFFFF and stays there. `load_req` together with `start` in HALT: next state is LOAD.
